// File: rtl/alu_ctrl_top.sv
// Sequenced ALU front end: buttons capture A, B and opcode in order from the
// switches, then one registered ALU operation drives the LEDs and flags.
module alu_ctrl_top #(
    parameter int N_BITS = 8,
    parameter int N_B    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_SWs,
    input  logic [N_B-1:0]    i_buttons,
    output logic [N_BITS-1:0] o_led,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow,
    output logic              o_valid,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam int                MSB       = N_BITS - 1;
    localparam logic [N_BITS-1:0] SHIFT_LIM = N_BITS[N_BITS-1:0];

    state_t              state_q, state_d;
    logic [N_B-1:0]      btn_q;
    logic [N_B-1:0]      btn_edge;
    logic [N_BITS-1:0]   a_q, a_d;
    logic [N_BITS-1:0]   b_q, b_d;
    logic [5:0]          op_q, op_d;
    logic [N_BITS-1:0]   led_q, led_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [N_BITS:0]          sum_w;
    logic [N_BITS-1:0]        diff_w;
    logic signed [N_BITS-1:0] a_s;
    logic signed [N_BITS-1:0] sra_w;
    logic                     shift_big;
    logic [N_BITS-1:0]        res_w;
    logic                     carry_w;
    logic                     ovf_w;
    logic                     err_w;

    assign btn_edge  = i_buttons & ~btn_q;
    assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w    = a_q - b_q;
    assign a_s       = $signed(a_q);
    assign sra_w     = a_s >>> b_q;
    assign shift_big = (b_q >= SHIFT_LIM);

    always_comb begin
        res_w   = '0;
        carry_w = 1'b0;
        ovf_w   = 1'b0;
        err_w   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_w   = sum_w[N_BITS-1:0];
                carry_w = sum_w[N_BITS];
                ovf_w   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_w   = diff_w;
                carry_w = (a_q < b_q);
                ovf_w   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
            end
            OP_AND: res_w = a_q & b_q;
            OP_OR:  res_w = a_q | b_q;
            OP_XOR: res_w = a_q ^ b_q;
            OP_NOR: res_w = ~(a_q | b_q);
            OP_SRL: res_w = shift_big ? '0 : (a_q >> b_q);
            OP_SRA: res_w = shift_big ? {N_BITS{a_q[MSB]}} : sra_w;
            default: err_w = 1'b1;
        endcase
    end

    // Each state reacts only to its own button edge; all others are ignored.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        led_d   = led_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_A: begin
                if (btn_edge[2]) begin
                    a_d     = i_SWs;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (btn_edge[1]) begin
                    b_d     = i_SWs;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (btn_edge[0]) begin
                    op_d    = i_SWs[5:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                led_d   = res_w;
                zero_d  = (res_w == '0);
                carry_d = carry_w;
                ovf_d   = ovf_w;
                err_d   = err_w;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (btn_edge[2]) begin
                    a_d     = i_SWs;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_B;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // btn_q resets to ones so a button held through reset must be re-pressed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_A;
            btn_q   <= '1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= i_buttons;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            led_q   <= led_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_led      = led_q;
    assign o_zero     = zero_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_alu_ctrl_top.sv
// Bench for alu_ctrl_top: directed stimulus pushes expected results into a
// queue, a monitor pops and compares on each rising o_valid.
module tb_alu_ctrl_top;

    logic       clock;
    logic       reset;
    logic [7:0] i_SWs;
    logic [2:0] i_buttons;
    logic [7:0] o_led;
    logic       o_zero;
    logic       o_carry;
    logic       o_overflow;
    logic       o_valid;
    logic       o_err;
    logic [2:0] o_state;

    alu_ctrl_top #(.N_BITS(8), .N_B(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_SWs      (i_SWs),
        .i_buttons  (i_buttons),
        .o_led      (o_led),
        .o_zero     (o_zero),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_state    (o_state)
    );

    typedef struct {
        logic [7:0] led;
        logic       z;
        logic       c;
        logic       v;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic press(input int k, input logic [7:0] sw);
        @(negedge clock);
        i_SWs        = sw;
        i_buttons    = 3'b000;
        i_buttons[k] = 1'b1;
        @(negedge clock);
        i_buttons = 3'b000;
    endtask

    task automatic press_op(input logic [7:0] op, input logic [7:0] led,
                            input logic z, input logic c, input logic v, input logic e);
        exp_t x;
        @(negedge clock);
        i_SWs     = op;
        i_buttons = 3'b001;
        x.led = led; x.z = z; x.c = c; x.v = v; x.e = e;
        x.cyc = cyc + 2;
        exp_q.push_back(x);
        @(negedge clock);
        i_buttons = 3'b000;
        repeat (2) @(negedge clock);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] led, input logic z, input logic c,
                          input logic v, input logic e);
        press(2, a);
        press(1, b);
        press_op(op, led, z, c, v, e);
    endtask

    // Monitor: compare on each rising edge of o_valid.
    initial begin
        logic prev_v;
        exp_t x;
        prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (o_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(o_led), 32'hFFFF_FFFF);
                end else begin
                    x = exp_q.pop_front();
                    chk("result", 32'({o_led, o_zero, o_carry, o_overflow, o_err, o_state}),
                        32'({x.led, x.z, x.c, x.v, x.e, 3'd4}));
                    chk("latency", 32'(cyc), 32'(x.cyc));
                end
            end
            prev_v = o_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        i_SWs     = 8'h00;
        i_buttons = 3'b000;
        repeat (2) @(negedge clock);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_outs", 32'({o_led, o_zero, o_carry, o_overflow, o_valid, o_err}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // B and OP pressed in S_A are ignored.
        i_buttons = 3'b011;
        @(negedge clock);
        i_buttons = 3'b000;
        @(negedge clock);
        chk("ignore_b_op_in_sa", 32'(o_state), 32'd0);

        // A and B together: only A acts.
        i_SWs     = 8'h7F;
        i_buttons = 3'b110;
        @(negedge clock);
        i_buttons = 3'b000;
        @(negedge clock);
        chk("a_b_together", 32'(o_state), 32'd1);

        // B held 10 cycles: one capture.
        i_SWs     = 8'h01;
        i_buttons = 3'b010;
        repeat (10) @(negedge clock);
        chk("b_held_state", 32'(o_state), 32'd2);
        i_buttons = 3'b000;
        press_op(8'h20, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

        run_op(8'h05, 8'h07, 8'h22, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(8'h07, 8'h07, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h02, 8'h03, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h09, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h08, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h09, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h08, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(8'h90, 8'h03, 8'h02, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h22, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'hF0, 8'h0F, 8'h25, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'hAA, 8'hFF, 8'h26, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h12, 8'h34, 8'hE0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(8'h5A, 8'hA5, 8'h3F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // A press in S_DONE clears o_valid and o_err.
        press(2, 8'h11);
        chk("clear_after_err", 32'({o_state, o_valid, o_err}), 32'({3'd1, 1'b0, 1'b0}));
        press(1, 8'h22);
        press_op(8'h20, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while in S_OP.
        press(2, 8'h44);
        press(1, 8'h55);
        chk("pre_reset_state", 32'(o_state), 32'd2);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_state", 32'(o_state), 32'd0);
        chk("mid_reset_outs", 32'({o_led, o_zero, o_carry, o_overflow, o_valid, o_err}), 32'd0);

        // A held across reset release: no capture until re-pressed.
        i_SWs     = 8'h09;
        i_buttons = 3'b100;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("held_a_no_capture", 32'(o_state), 32'd0);
        i_buttons = 3'b000;
        @(negedge clock);
        press(2, 8'h09);
        chk("a_repressed", 32'(o_state), 32'd1);
        press(1, 8'h03);
        press_op(8'h22, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
